bitrev_perm_ctrl: RTL and testbench
===================================

Name: bitrev_perm_ctrl

Overview:
Sequencer that drives the registered bit-reversal unit over a full index space of 2^(RADIX_K1*l) entries. Each result is paired with its source index and emitted as a (src, dst) permutation pair over a valid/ready interface to the memory reorder stage. Optional swap-only mode emits each in-place swap exactly once. Sits between the NTT stage controller (start/config) and the coefficient memory permutation logic.

Parameters:
D_WIDTH, 12, index width; matches the bit-reversal unit input/output width
RADIX_K1, 2, bits reversed per level; reversal width W = RADIX_K1*l

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  start request; sampled only in IDLE
cfg_l  input  3  level count l; latched on accepted start
swap_only  input  1  1: emit only pairs with src<dst; latched on accepted start
busy  output  1  high in RUN
done  output  1  one-cycle pulse at sweep completion
cfg_err  output  1  one-cycle pulse when start is rejected
br_idx  output  D_WIDTH  index to bit-reversal unit (input_idx)
br_enable  output  1  enable to bit-reversal unit
br_l  output  3  l to bit-reversal unit (latched cfg_l)
br_out  input  D_WIDTH  registered result from bit-reversal unit, 1-cycle latency
pair_valid  output  1  pair available
pair_ready  input  1  consumer accepts pair
pair_src  output  D_WIDTH  source index
pair_dst  output  D_WIDTH  bit-reversed index (= br_out)
pair_count  output  D_WIDTH+1  pairs accepted in current/last sweep

Behaviour:
- Reset (sync): state=IDLE; busy, done, cfg_err, br_enable, pair_valid = 0; br_idx, br_l, pair_src, pair_count = 0; internal cnt and s1 cleared. Reset mid-sweep aborts with no done pulse. The same rst drives the bit-reversal unit.
- States: IDLE, RUN, DONE.
- IDLE: start=1 with W=RADIX_K1*cfg_l, 1<=W<=D_WIDTH -> latch l and swap_only, cnt=0, pair_count=0, go to RUN.
- IDLE: start=1 with cfg_l=0 or W>D_WIDTH -> cfg_err=1 next cycle, stay in IDLE, latched config unchanged.
- start outside IDLE is ignored.
- N = 2^W; cnt is D_WIDTH+1 bits wide.
- Stage s1 tracks the index whose result is in br_out: s1_v, s1_src.
- pair_src = s1_src.
- pair_dst = br_out.
- pair_valid = s1_v AND (NOT swap_only OR s1_src < br_out).
- stall = pair_valid AND NOT pair_ready.
- RUN, stall: br_enable=1, br_idx=s1_src (re-issue, so br_out holds); cnt and s1 hold.
- RUN, no stall, cnt<N: br_enable=1, br_idx=cnt. At the clock edge: s1_src<=cnt, s1_v<=1, cnt<=cnt+1.
- RUN, no stall, cnt==N: br_enable=0, br_idx=0, s1_v<=0.
- When s1_v retires with cnt==N, go to DONE.
- s1_v retires (non-stall) whether or not it produced a pair. Skipped entries (swap_only, src>=dst) cost exactly one cycle.
- pair_count increments on each pair_valid AND pair_ready. Saturation is not possible because the count is at most N.
- DONE: done=1 for one cycle, then IDLE. pair_count holds until the next accepted start.
- busy=1 exactly while in RUN.
- Throughput with pair_ready=1: one index per cycle.
- Latency: start sampled in cycle t -> first issue at t+1 -> first pair at t+2 -> last pair at t+N+1 -> done at t+N+2.
- pair_src and pair_dst must stay stable while pair_valid=1 and pair_ready=0.

Test Plan:
- Full mode, l=2 (W=4, N=16), pair_ready=1, start at t -> 16 pairs in cycles t+2..t+17. Includes (0,0), (1,8), (3,12), (5,10), (15,15). done at t+18, pair_count=16, busy high t+1..t+17.
- swap_only=1, l=2 -> exactly 6 pairs: (1,8), (2,4), (3,12), (5,10), (7,14), (11,13). pair_count=6; done still at t+18.
- Backpressure: full mode l=2, pair_ready=0 for 3 cycles while pair (5,10) is shown -> pair_src=5 and pair_dst=10 held stable, br_idx=5 re-issued each stalled cycle. No pair lost or duplicated; done delayed by 3 cycles.
- Config errors: cfg_l=0 -> cfg_err pulse, busy stays 0. cfg_l=7 (W=14>12) -> cfg_err pulse. A following start with l=6 (W=12) is accepted and sweeps 4096 indices.
- Reset mid-sweep: rst asserted at cnt=7, l=2 -> next cycle all outputs 0, state IDLE, no done. A new start runs a clean 16-pair sweep.
- start pulses during RUN -> ignored, and the sweep output is identical to the uninterrupted run.

Source files
------------

// File: rtl/bitrev_perm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_perm_ctrl_if
// Brief    : (src, dst) permutation-pair valid/ready channel
// Revision : 1.0
// ============================================================================
interface bitrev_perm_ctrl_if #(
  parameter int D_WIDTH = 12
);
  logic               pair_valid;
  logic               pair_ready;
  logic [D_WIDTH-1:0] pair_src;
  logic [D_WIDTH-1:0] pair_dst;

  modport master (
    output pair_valid,
    output pair_src,
    output pair_dst,
    input  pair_ready
  );

  modport slave (
    input  pair_valid,
    input  pair_src,
    input  pair_dst,
    output pair_ready
  );
endinterface
`default_nettype wire

// File: rtl/bitrev_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_perm_ctrl
// Brief    : Sweeps a bit-reversal unit over 2^W indices, emitting (src, dst)
//            permutation pairs; optional swap-only mode emits each swap once.
// Revision : 1.0
// ============================================================================
module bitrev_perm_ctrl #(
  parameter int D_WIDTH  = 12,
  parameter int RADIX_K1 = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  input  wire logic [2:0]         cfg_l,
  input  wire logic               swap_only,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [D_WIDTH-1:0]      br_idx,
  output logic                    br_enable,
  output logic [2:0]              br_l,
  input  wire logic [D_WIDTH-1:0] br_out,
  bitrev_perm_ctrl_if.master      pair,
  output logic [D_WIDTH:0]        pair_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH:0]   cnt_q, cnt_d;
  logic               s1_v_q, s1_v_d;
  logic [D_WIDTH-1:0] s1_src_q, s1_src_d;
  logic [2:0]         l_q, l_d;
  logic               swap_q, swap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [D_WIDTH:0]   pair_count_q, pair_count_d;

  logic [31:0]        req_w;
  logic               cfg_ok;
  logic [31:0]        run_w;
  logic [D_WIDTH:0]   n_idx;
  logic               cnt_lt_n;
  logic               pair_valid_w;
  logic               stall;

  always_comb begin
    req_w    = 32'(RADIX_K1) * 32'(cfg_l);
    cfg_ok   = (cfg_l != 3'd0) && (req_w <= 32'(D_WIDTH));
    run_w    = 32'(RADIX_K1) * 32'(l_q);
    n_idx    = {{D_WIDTH{1'b0}}, 1'b1} << run_w;
    cnt_lt_n = cnt_q < n_idx;
  end

  // br_out always holds the result for s1_src, so the pair is formed directly from it
  always_comb begin
    pair_valid_w    = s1_v_q && (!swap_q || (s1_src_q < br_out));
    stall           = pair_valid_w && !pair.pair_ready;
    pair.pair_valid = pair_valid_w;
    pair.pair_src   = s1_src_q;
    pair.pair_dst   = br_out;
  end

  // Re-issuing s1_src during a stall keeps the registered unit output frozen
  always_comb begin
    br_enable = 1'b0;
    br_idx    = '0;
    if (state_q == ST_RUN) begin
      if (stall) begin
        br_enable = 1'b1;
        br_idx    = s1_src_q;
      end else if (cnt_lt_n) begin
        br_enable = 1'b1;
        br_idx    = cnt_q[D_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s1_v_d       = s1_v_q;
    s1_src_d     = s1_src_q;
    l_d          = l_q;
    swap_d       = swap_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    pair_count_d = pair_count_q;

    if (pair_valid_w && pair.pair_ready) begin
      pair_count_d = pair_count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            l_d          = cfg_l;
            swap_d       = swap_only;
            cnt_d        = '0;
            s1_v_d       = 1'b0;
            pair_count_d = '0;
            busy_d       = 1'b1;
            state_d      = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (cnt_lt_n) begin
            s1_src_d = cnt_q[D_WIDTH-1:0];
            s1_v_d   = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            s1_v_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        s1_v_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      s1_v_q       <= 1'b0;
      s1_src_q     <= '0;
      l_q          <= 3'd0;
      swap_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_v_q       <= s1_v_d;
      s1_src_q     <= s1_src_d;
      l_q          <= l_d;
      swap_q       <= swap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign br_l       = l_q;
  assign pair_count = pair_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bitrev_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitrev_perm_ctrl
// Brief    : Directed/randomized sweeps of bitrev_perm_ctrl against a model
// Revision : 1.0
// ============================================================================
module tb_bitrev_perm_ctrl;
  localparam int D_WIDTH  = 12;
  localparam int RADIX_K1 = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [2:0]         cfg_l;
  logic               swap_only;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [D_WIDTH-1:0] br_idx;
  logic               br_enable;
  logic [2:0]         br_l;
  logic [D_WIDTH-1:0] br_out;
  logic [D_WIDTH:0]   pair_count;

  int vectors     = 0;
  int miscompares = 0;

  bitrev_perm_ctrl_if #(.D_WIDTH(D_WIDTH)) pif ();

  bitrev_perm_ctrl #(.D_WIDTH(D_WIDTH), .RADIX_K1(RADIX_K1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_l      (cfg_l),
    .swap_only  (swap_only),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .br_idx     (br_idx),
    .br_enable  (br_enable),
    .br_l       (br_l),
    .br_out     (br_out),
    .pair       (pif),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) begin
      if (((v >> i) & 1) != 0) r |= (1 << (w - 1 - i));
    end
    return r;
  endfunction

  // Registered bit-reversal unit with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) br_out <= '0;
    else if (br_enable) br_out <= D_WIDTH'(rev(int'(br_idx), RADIX_K1 * int'(br_l)));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},       32'(busy),            0);
    check({tag, ".done"},       32'(done),            0);
    check({tag, ".cfg_err"},    32'(cfg_err),         0);
    check({tag, ".br_enable"},  32'(br_enable),       0);
    check({tag, ".pair_valid"}, 32'(pif.pair_valid),  0);
    check({tag, ".br_idx"},     32'(br_idx),          0);
    check({tag, ".br_l"},       32'(br_l),            0);
    check({tag, ".pair_src"},   32'(pif.pair_src),    0);
    check({tag, ".pair_dst"},   32'(pif.pair_dst),    0);
    check({tag, ".pair_count"}, 32'(pair_count),      0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 hold ready low 3 cycles on src 5
  task automatic run_sweep(input int l, input bit swp, input int rmode,
                           input bit noisy, input int abort_k);
    int  w, n, s, stalls, accepted, exp_total, held, done_k;
    bit  ev, rdy;
    w = RADIX_K1 * l;
    n = 1 << w;
    exp_total = 0;
    for (int i = 0; i < n; i++) if (!swp || i < rev(i, w)) exp_total++;

    @(negedge clk);
    start     = 1'b1;
    cfg_l     = 3'(l);
    swap_only = swp;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_l     = 3'($urandom);
    swap_only = 1'($urandom);

    stalls   = 0;
    accepted = 0;
    held     = 0;
    for (int k = 1; ; k++) begin
      @(negedge clk);
      done_k = n + 2 + stalls;
      s  = k - 2 - stalls;
      ev = (s >= 0) && (s < n) && (!swp || s < rev(s, w));
      case (rmode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(ev && s == 5 && held < 3);
        default: rdy = 1'b1;
      endcase
      pif.pair_ready = rdy;
      start = (noisy && k < done_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) cfg_l = 3'($urandom);

      if (k == abort_k) begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("abort");
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          #1;
          check("abort.no_done", 32'(done), 0);
          check("abort.idle",    32'(busy), 0);
        end
        return;
      end

      #1;
      if (k == done_k) begin
        check("done.pulse",      32'(done),           1);
        check("done.busy",       32'(busy),           0);
        check("done.valid",      32'(pif.pair_valid), 0);
        check("done.pair_count", 32'(pair_count),     32'(exp_total));
        break;
      end

      check("run.busy",       32'(busy),           1);
      check("run.done",       32'(done),           0);
      check("run.br_l",       32'(br_l),           32'(l));
      check("run.pair_valid", 32'(pif.pair_valid), 32'(ev));
      check("run.pair_count", 32'(pair_count),     32'(accepted));
      if (ev) begin
        check("pair.src", 32'(pif.pair_src), 32'(s));
        check("pair.dst", 32'(pif.pair_dst), 32'(rev(s, w)));
      end
      if (ev && !rdy) begin
        check("stall.br_enable", 32'(br_enable), 1);
        check("stall.br_idx",    32'(br_idx),    32'(s));
        stalls++;
        held++;
      end else begin
        check("issue.br_enable", 32'(br_enable), 32'(s + 1 < n));
        check("issue.br_idx",    32'(br_idx),    (s + 1 < n) ? 32'(s + 1) : 32'd0);
      end
      if (ev && rdy) accepted++;
    end

    start = 1'b0;
    pif.pair_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post.done",       32'(done),       0);
    check("post.busy",       32'(busy),       0);
    check("post.pair_count", 32'(pair_count), 32'(exp_total));
  endtask

  task automatic cfg_err_case(input int bad_l, input int held_l);
    @(negedge clk);
    start = 1'b1;
    cfg_l = 3'(bad_l);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("cfgerr.pulse", 32'(cfg_err), 1);
    check("cfgerr.busy",  32'(busy),    0);
    check("cfgerr.br_l",  32'(br_l),    32'(held_l));
    @(negedge clk);
    check("cfgerr.clear", 32'(cfg_err), 0);
    check("cfgerr.idle",  32'(busy),    0);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_l          = 3'd0;
    swap_only      = 1'b0;
    pif.pair_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_sweep(2, 1'b0, 0, 1'b0, 0);
    run_sweep(2, 1'b1, 0, 1'b0, 0);
    run_sweep(2, 1'b0, 2, 1'b0, 0);

    cfg_err_case(0, 2);
    cfg_err_case(7, 2);
    run_sweep(6, 1'b0, 1, 1'b0, 0);

    run_sweep(2, 1'b0, 0, 1'b0, 8);
    run_sweep(2, 1'b0, 0, 1'b0, 0);

    run_sweep(2, 1'b0, 0, 1'b1, 0);
    run_sweep(3, 1'b1, 1, 1'b1, 0);

    for (int i = 0; i < 4; i++) begin
      run_sweep(int'($urandom_range(1, 4)), 1'($urandom), 1, 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
